tl_tx_fc_credit_gate: RTL and testbench

Transmit-side flow-control credit gate for the TL TX path. It is the counterpart of the RX FC counters. For each TLP type (Posted, Non-Posted, Completion) it tracks the Credit Limit (CL), loaded from InitFC and UpdateFC DLLPs forwarded by the DLL, and the Credits Consumed (CC), advanced on each granted TLP. The TX arbiter may launch a TLP only after this block asserts `tlp_grant`.

---
 rtl/tl_tx_fc_credit_gate.sv | 169 ++++++++++++++++
 tb/tb_tl_tx_fc_credit_gate.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tx_fc_credit_gate.sv
// TX flow-control credit gate: per-type credit limit / consumed tracking that gates TLP launch.
// Grant two cycles after a request is sampled (one per 3 cycles); stalls in CHECK until credits suffice.
module tl_tx_fc_credit_gate #(
  parameter int PAYLOAD_LENGTH  = 10,
  parameter int HDR_FIELD_SIZE  = 8,
  parameter int DATA_FIELD_SIZE = 12,
  parameter int HDR_CNT_W       = HDR_FIELD_SIZE + 4,
  parameter int DATA_CNT_W      = DATA_FIELD_SIZE + 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dll_fc_valid,
  input  logic                       dll_fc_init,
  input  logic [1:0]                 dll_fc_typ,
  input  logic [HDR_FIELD_SIZE-1:0]  dll_hdr_fc,
  input  logic [DATA_FIELD_SIZE-1:0] dll_data_fc,
  input  logic [1:0]                 dll_hdr_scale,
  input  logic [1:0]                 dll_data_scale,
  input  logic                       tlp_req_valid,
  input  logic [1:0]                 tlp_typ,
  input  logic                       tlp_has_data,
  input  logic [PAYLOAD_LENGTH-1:0]  tlp_length_dw,
  output logic                       tlp_grant,
  output logic [2:0]                 fc_init_done,
  output logic                       credit_stall
);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DONE} state_t;

  localparam logic [HDR_CNT_W-1:0]  HDR_HALF  = {1'b1, {(HDR_CNT_W-1){1'b0}}};
  localparam logic [DATA_CNT_W-1:0] DATA_HALF = {1'b1, {(DATA_CNT_W-1){1'b0}}};

  // Index 3 is the unused type code; its entries stay at reset so it never grants.
  logic [HDR_CNT_W-1:0]  hdr_cl     [4];
  logic [HDR_CNT_W-1:0]  hdr_cc     [4];
  logic [DATA_CNT_W-1:0] data_cl    [4];
  logic [DATA_CNT_W-1:0] data_cc    [4];
  logic [1:0]            hdr_scale  [4];
  logic [1:0]            data_scale [4];
  logic [3:0]            hdr_inf;
  logic [3:0]            data_inf;
  logic [3:0]            init_done;

  state_t                state;
  logic [1:0]            req_typ;
  logic [DATA_CNT_W-1:0] req_data_need;

  logic [PAYLOAD_LENGTH:0] len_full;
  logic [DATA_CNT_W-1:0]   data_need;
  logic [HDR_CNT_W-1:0]    hdr_room;
  logic [DATA_CNT_W-1:0]   data_room;
  logic                    hdr_ok;
  logic                    data_ok;
  logic                    credit_ok;

  function automatic logic [HDR_CNT_W-1:0] scale_hdr(input logic [HDR_FIELD_SIZE-1:0] f,
                                                     input logic [1:0] s);
    logic [HDR_CNT_W-1:0] v;
    v = HDR_CNT_W'(f);
    case (s)
      2'b10:   scale_hdr = v << 2;
      2'b11:   scale_hdr = v << 4;
      default: scale_hdr = v;
    endcase
  endfunction

  function automatic logic [DATA_CNT_W-1:0] scale_data(input logic [DATA_FIELD_SIZE-1:0] f,
                                                       input logic [1:0] s);
    logic [DATA_CNT_W-1:0] v;
    v = DATA_CNT_W'(f);
    case (s)
      2'b10:   scale_data = v << 2;
      2'b11:   scale_data = v << 4;
      default: scale_data = v;
    endcase
  endfunction

  assign fc_init_done = init_done[2:0];

  // Length 0 encodes the maximum payload; data credits are 4-DW units rounded up.
  always_comb begin
    len_full  = (tlp_length_dw == '0) ? {1'b1, {PAYLOAD_LENGTH{1'b0}}} : {1'b0, tlp_length_dw};
    data_need = tlp_has_data ? ((DATA_CNT_W'(len_full) + DATA_CNT_W'(3)) >> 2) : '0;
  end

  // Modular distance from consumed-after-grant to the limit; "behind" wraps above half range.
  always_comb begin
    hdr_room  = hdr_cl[req_typ] - hdr_cc[req_typ] - HDR_CNT_W'(1);
    data_room = data_cl[req_typ] - data_cc[req_typ] - req_data_need;
    hdr_ok    = hdr_inf[req_typ] || (hdr_room <= HDR_HALF);
    data_ok   = data_inf[req_typ] || (req_data_need == '0) || (data_room <= DATA_HALF);
    credit_ok = init_done[req_typ] && hdr_ok && data_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hdr_cl[i]     <= '0;
        data_cl[i]    <= '0;
        hdr_scale[i]  <= '0;
        data_scale[i] <= '0;
      end
      hdr_inf   <= '0;
      data_inf  <= '0;
      init_done <= '0;
    end else if (dll_fc_valid && (dll_fc_typ != 2'b11)) begin
      if (dll_fc_init) begin
        if (!init_done[dll_fc_typ]) begin
          hdr_scale[dll_fc_typ]  <= dll_hdr_scale;
          data_scale[dll_fc_typ] <= dll_data_scale;
          hdr_cl[dll_fc_typ]     <= scale_hdr(dll_hdr_fc, dll_hdr_scale);
          data_cl[dll_fc_typ]    <= scale_data(dll_data_fc, dll_data_scale);
          hdr_inf[dll_fc_typ]    <= (dll_hdr_fc == '0);
          data_inf[dll_fc_typ]   <= (dll_data_fc == '0);
          init_done[dll_fc_typ]  <= 1'b1;
        end
      end else if (init_done[dll_fc_typ]) begin
        if (!hdr_inf[dll_fc_typ])
          hdr_cl[dll_fc_typ] <= scale_hdr(dll_hdr_fc, hdr_scale[dll_fc_typ]);
        if (!data_inf[dll_fc_typ])
          data_cl[dll_fc_typ] <= scale_data(dll_data_fc, data_scale[dll_fc_typ]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      req_typ       <= '0;
      req_data_need <= '0;
      tlp_grant     <= 1'b0;
      credit_stall  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hdr_cc[i]  <= '0;
        data_cc[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          tlp_grant <= 1'b0;
          if (tlp_req_valid) begin
            req_typ       <= tlp_typ;
            req_data_need <= data_need;
            state         <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (credit_ok) begin
            tlp_grant    <= 1'b1;
            credit_stall <= 1'b0;
            if (!hdr_inf[req_typ])
              hdr_cc[req_typ] <= hdr_cc[req_typ] + HDR_CNT_W'(1);
            if (!data_inf[req_typ])
              data_cc[req_typ] <= data_cc[req_typ] + req_data_need;
            state <= ST_DONE;
          end else begin
            credit_stall <= 1'b1;
          end
        end
        ST_DONE: begin
          tlp_grant <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_tx_fc_credit_gate.sv
// Self-checking bench for tl_tx_fc_credit_gate against a spec-level credit model.
module tb_tl_tx_fc_credit_gate;
  localparam int PL = 10;
  localparam int HF = 8;
  localparam int DF = 12;
  localparam int HW = HF + 4;
  localparam int DW = DF + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          dll_fc_valid, dll_fc_init;
  logic [1:0]    dll_fc_typ;
  logic [HF-1:0] dll_hdr_fc;
  logic [DF-1:0] dll_data_fc;
  logic [1:0]    dll_hdr_scale, dll_data_scale;
  logic          tlp_req_valid;
  logic [1:0]    tlp_typ;
  logic          tlp_has_data;
  logic [PL-1:0] tlp_length_dw;
  logic          tlp_grant;
  logic [2:0]    fc_init_done;
  logic          credit_stall;

  int errors = 0;
  int checks = 0;

  int m_hcl[3], m_hcc[3], m_dcl[3], m_dcc[3], m_hs[3], m_ds[3];
  bit m_hinf[3], m_dinf[3], m_init[3];

  tl_tx_fc_credit_gate dut (
    .clk(clk), .rst(rst),
    .dll_fc_valid(dll_fc_valid), .dll_fc_init(dll_fc_init), .dll_fc_typ(dll_fc_typ),
    .dll_hdr_fc(dll_hdr_fc), .dll_data_fc(dll_data_fc),
    .dll_hdr_scale(dll_hdr_scale), .dll_data_scale(dll_data_scale),
    .tlp_req_valid(tlp_req_valid), .tlp_typ(tlp_typ), .tlp_has_data(tlp_has_data),
    .tlp_length_dw(tlp_length_dw), .tlp_grant(tlp_grant),
    .fc_init_done(fc_init_done), .credit_stall(credit_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int mult(int s);
    return (s == 2) ? 4 : (s == 3) ? 16 : 1;
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < 3; t++) begin
      m_hcl[t] = 0; m_hcc[t] = 0; m_dcl[t] = 0; m_dcc[t] = 0;
      m_hs[t] = 0; m_ds[t] = 0; m_hinf[t] = 0; m_dinf[t] = 0; m_init[t] = 0;
    end
  endfunction

  function automatic void model_dllp(bit init, int t, int h, int d, int hs, int ds);
    if (t > 2) return;
    if (init) begin
      if (!m_init[t]) begin
        m_hs[t] = hs; m_ds[t] = ds;
        m_hcl[t] = (h * mult(hs)) % (1 << HW);
        m_dcl[t] = (d * mult(ds)) % (1 << DW);
        m_hinf[t] = (h == 0); m_dinf[t] = (d == 0); m_init[t] = 1;
      end
    end else if (m_init[t]) begin
      if (!m_hinf[t]) m_hcl[t] = (h * mult(m_hs[t])) % (1 << HW);
      if (!m_dinf[t]) m_dcl[t] = (d * mult(m_ds[t])) % (1 << DW);
    end
  endfunction

  function automatic int model_need(bit hd, int len);
    return hd ? ((((len == 0) ? 1024 : len) + 3) / 4) : 0;
  endfunction

  function automatic bit room(int cl, int cc, int need, int w);
    return ((cl - cc - need) & ((1 << w) - 1)) <= (1 << (w - 1));
  endfunction

  function automatic bit model_ok(int t, int need);
    return m_init[t] && (m_hinf[t] || room(m_hcl[t], m_hcc[t], 1, HW))
                     && (m_dinf[t] || need == 0 || room(m_dcl[t], m_dcc[t], need, DW));
  endfunction

  function automatic void model_consume(int t, int need);
    if (!m_hinf[t]) m_hcc[t] = (m_hcc[t] + 1) % (1 << HW);
    if (!m_dinf[t]) m_dcc[t] = (m_dcc[t] + need) % (1 << DW);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tlp_req_valid = 1'b0; dll_fc_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic send_dllp(bit init, int t, int h, int d, int hs, int ds);
    dll_fc_init = init; dll_fc_typ = 2'(t); dll_hdr_fc = HF'(h); dll_data_fc = DF'(d);
    dll_hdr_scale = 2'(hs); dll_data_scale = 2'(ds); dll_fc_valid = 1'b1;
    tick();
    dll_fc_valid = 1'b0;
    model_dllp(init, t, h, d, hs, ds);
  endtask

  task automatic start_req(int t, bit hd, int len);
    tlp_typ = 2'(t); tlp_has_data = hd; tlp_length_dw = PL'(len); tlp_req_valid = 1'b1;
  endtask

  task automatic wait_grant(int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (tlp_grant === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic end_req();
    tlp_req_valid = 1'b0;
    tick();
  endtask

  task automatic abort_pending();
    tlp_req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (tlp_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b want=0", tlp_grant); end
    checks++; if (fc_init_done !== 3'b000) begin errors++; $display("FAIL reset_init_done got=%b want=000", fc_init_done); end
    checks++; if (credit_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", credit_stall); end
  endtask

  task automatic test_no_init();
    int n;
    start_req(0, 1'b1, 4);
    wait_grant(20, n);
    checks++; if (n != -1) begin errors++; $display("FAIL noinit_grant got latency=%0d want none", n); end
    checks++; if (credit_stall !== 1'b1) begin errors++; $display("FAIL noinit_stall got=%b want=1", credit_stall); end
    rst = 1'b1; tlp_req_valid = 1'b0;
    tick();
    checks++; if (credit_stall !== 1'b0 || tlp_grant !== 1'b0) begin
      errors++; $display("FAIL midcheck_rst stall=%b grant=%b want 0/0", credit_stall, tlp_grant);
    end
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic test_p_credits();
    int n; bit exp;
    send_dllp(1, 0, 2, 8, 1, 1);
    checks++; if (fc_init_done !== 3'b001) begin errors++; $display("FAIL p_init_done got=%b want=001", fc_init_done); end
    send_dllp(1, 0, 50, 0, 0, 0);  // repeated InitFC must not reload or go infinite
    for (int i = 0; i < 3; i++) begin
      exp = model_ok(0, 1);
      start_req(0, 1'b1, 4);
      wait_grant(4, n);
      checks++; if ((n == 2) !== exp) begin errors++; $display("FAIL p_req[%0d] latency=%0d want_grant=%0d", i, n, exp); end
      if (n == 2) begin model_consume(0, 1); end_req(); end
    end
    checks++; if (credit_stall !== 1'b1) begin errors++; $display("FAIL p_third_stall got=%b want=1", credit_stall); end
    send_dllp(0, 0, 3, 8, 0, 0);
    checks++; if (tlp_grant !== 1'b0) begin errors++; $display("FAIL p_update_early got=%b want=0", tlp_grant); end
    tick();
    checks++; if (tlp_grant !== 1'b1 || credit_stall !== 1'b0) begin
      errors++; $display("FAIL p_update_grant grant=%b stall=%b want 1/0", tlp_grant, credit_stall);
    end
    model_consume(0, 1); end_req();
    // Lowering update on the same edge as the CHECK decision: old limit decides.
    send_dllp(0, 0, 5, 8, 0, 0);
    start_req(0, 1'b0, 1);
    tick();
    exp = model_ok(0, 0);
    model_consume(0, 0);
    send_dllp(0, 0, 3, 8, 0, 0);
    checks++; if (tlp_grant !== exp) begin errors++; $display("FAIL p_same_edge grant=%b want=%b", tlp_grant, exp); end
    end_req();
    exp = model_ok(0, 0);
    start_req(0, 1'b0, 1);
    wait_grant(4, n);
    checks++; if ((n == 2) !== exp) begin errors++; $display("FAIL p_after_lower latency=%0d want_grant=%0d", n, exp); end
    send_dllp(0, 0, 6, 8, 0, 0);
    tick();
    checks++; if (tlp_grant !== 1'b1) begin errors++; $display("FAIL p_recover grant=%b want=1", tlp_grant); end
    model_consume(0, 0); end_req();
  endtask

  task automatic test_np_infinite();
    int n;
    send_dllp(1, 1, 0, 0, 1, 1);
    checks++; if (fc_init_done !== 3'b011) begin errors++; $display("FAIL np_init_done got=%b want=011", fc_init_done); end
    for (int i = 0; i < 100; i++) begin
      if (i == 50) send_dllp(0, 1, 1, 0, 0, 0);
      start_req(1, 1'b1, 1);
      wait_grant(4, n);
      checks++; if (n != 2) begin
        errors++; $display("FAIL np_grant[%0d] latency=%0d want=2", i, n);
        abort_pending(); break;
      end
      model_consume(1, 1); end_req();
      checks++; if (tlp_grant !== 1'b0) begin errors++; $display("FAIL np_pulse[%0d] grant=%b want=0", i, tlp_grant); end
    end
  endtask

  task automatic test_cpl_large();
    int n;
    send_dllp(1, 2, 10, 255, 1, 1);
    checks++; if (fc_init_done !== 3'b111) begin errors++; $display("FAIL cpl_init_done got=%b want=111", fc_init_done); end
    for (int k = 0; k < 2; k++) begin
      // k=0: 256-credit payload vs limit 255; k=1: 1 credit with consumed 256 == limit 256
      start_req(2, 1'b1, (k == 0) ? 0 : 4);
      wait_grant(4, n);
      checks++; if (n != -1 || credit_stall !== 1'b1) begin
        errors++; $display("FAIL cpl_stall[%0d] latency=%0d stall=%b want none/1", k, n, credit_stall);
      end
      send_dllp(0, 2, 10, (k == 0) ? 256 : 257, 0, 0);
      tick();
      checks++; if (tlp_grant !== 1'b1) begin errors++; $display("FAIL cpl_grant[%0d] got=%b want=1", k, tlp_grant); end
      model_consume(2, (k == 0) ? 256 : 1); end_req();
    end
  endtask

  task automatic test_cpl_scale();
    int n;
    do_reset();
    send_dllp(1, 2, 1, 0, 3, 1);
    for (int i = 0; i < 17; i++) begin
      start_req(2, 1'b0, 1);
      wait_grant(4, n);
      checks++; if ((n == 2) !== (i < 16)) begin errors++; $display("FAIL cpl_scale[%0d] latency=%0d want_grant=%0d", i, n, i < 16); end
      if (n == 2) begin model_consume(2, 0); end_req(); end
    end
    send_dllp(0, 2, 2, 0, 0, 0);
    tick();
    checks++; if (tlp_grant !== 1'b1) begin errors++; $display("FAIL cpl_scale_update grant=%b want=1", tlp_grant); end
    end_req();
  endtask

  task automatic test_p_wrap();
    int n; bit exp;
    do_reset();
    send_dllp(1, 0, 8, 0, 3, 1);
    for (int g = 0; g < 5000; g++) begin
      if (g > 0 && g % 100 == 0) send_dllp(0, 0, ((m_hcc[0] + 150) / 16) % 256, 0, 0, 0);
      exp = model_ok(0, 0);
      start_req(0, 1'b0, 1);
      wait_grant(4, n);
      checks++; if ((n == 2) !== exp) begin
        errors++; $display("FAIL wrap[%0d] latency=%0d want_grant=%0d cc=%0d", g, n, exp, m_hcc[0]);
        abort_pending(); break;
      end
      model_consume(0, 0); end_req();
    end
  endtask

  task automatic test_random();
    int n, t, len, need, hf, df; bit hd, exp;
    do_reset();
    for (int t0 = 0; t0 < 3; t0++)
      send_dllp(1, t0, $urandom_range(0, 20), $urandom_range(0, 300), $urandom_range(0, 3), $urandom_range(0, 3));
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0)
        send_dllp(0, $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 600), 0, 0);
      t = $urandom_range(0, 2); hd = 1'($urandom_range(0, 1)); len = $urandom_range(1, 64);
      need = model_need(hd, len); exp = model_ok(t, need);
      start_req(t, hd, len);
      wait_grant(4, n);
      checks++; if ((n == 2) !== exp) begin
        errors++; $display("FAIL rand[%0d] typ=%0d need=%0d latency=%0d want_grant=%0d", it, t, need, n, exp);
        abort_pending(); break;
      end
      if (!exp) begin
        checks++; if (credit_stall !== 1'b1) begin errors++; $display("FAIL rand_stall[%0d] got=%b want=1", it, credit_stall); end
        hf = (m_hcc[t] + 1) / mult(m_hs[t]) + 1;
        df = (m_dcc[t] + need) / mult(m_ds[t]) + 1;
        send_dllp(0, t, hf, df, 0, 0);
        checks++; if (tlp_grant !== 1'b0) begin errors++; $display("FAIL rand_early[%0d] got=%b want=0", it, tlp_grant); end
        tick();
        checks++; if (tlp_grant !== 1'b1 || credit_stall !== 1'b0) begin
          errors++; $display("FAIL rand_resolve[%0d] grant=%b stall=%b want 1/0", it, tlp_grant, credit_stall);
          abort_pending(); break;
        end
      end
      model_consume(t, need); end_req();
    end
  endtask

  initial begin
    rst = 1'b1; dll_fc_valid = 1'b0; dll_fc_init = 1'b0; dll_fc_typ = 2'b00;
    dll_hdr_fc = '0; dll_data_fc = '0; dll_hdr_scale = 2'b00; dll_data_scale = 2'b00;
    tlp_req_valid = 1'b0; tlp_typ = 2'b00; tlp_has_data = 1'b0; tlp_length_dw = '0;
    model_reset();
    test_reset();
    test_no_init();
    test_p_credits();
    test_np_infinite();
    test_cpl_large();
    test_cpl_scale();
    test_p_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
